// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the multi-word ripple-carry add/subtract sequencer.
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell used to build the ripple-carry slice.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/module_rca_cin.sv
// WIDTH-bit ripple-carry adder with explicit carry-in and carry-out.
module module_rca_cin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder_1bit u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/module_rca_seq_ctrl.sv
// Multi-word add/subtract sequencer: one WIDTH-bit slice, one word per cycle, LSW first,
// with the inter-word carry held in a register.
module module_rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic                      clk_pi,
    input  logic                      rst_n_pi,
    input  logic                      valid_pi,
    output logic                      ready_po,
    input  logic                      op_pi,
    input  logic [WIDTH*NWORDS-1:0]   a_pi,
    input  logic [WIDTH*NWORDS-1:0]   b_pi,
    output logic                      busy_po,
    output logic                      done_po,
    output logic [WIDTH*NWORDS:0]     result_po
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t                         state, state_nxt;
    logic [NWORDS-1:0][WIDTH-1:0]   a_reg, b_reg, work_reg, work_nxt;
    logic                           carry_reg;
    logic [IDX_W-1:0]               idx;
    logic [WIDTH*NWORDS:0]          result_reg;
    logic [WIDTH-1:0]               slice_sum;
    logic                           slice_cout;
    logic                           accept;

    module_rca_cin #(.WIDTH(WIDTH)) u_slice (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        ready_po      = 1'b0;
        busy_po       = 1'b0;
        done_po       = 1'b0;
        work_nxt      = work_reg;
        work_nxt[idx] = slice_sum;
        case (state)
            IDLE: begin
                ready_po = 1'b1;
                if (valid_pi) state_nxt = RUN;
            end
            RUN: begin
                busy_po = 1'b1;
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                busy_po   = 1'b1;
                done_po   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = valid_pi & ready_po;
    assign result_po = result_reg;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            work_reg   <= '0;
            carry_reg  <= 1'b0;
            idx        <= '0;
            result_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
                a_reg     <= a_pi;
                b_reg     <= (op_pi == OP_SUB) ? ~b_pi : b_pi;
                carry_reg <= (op_pi == OP_SUB);
                idx       <= '0;
            end else if (state == RUN) begin
                work_reg  <= work_nxt;
                carry_reg <= slice_cout;
                idx       <= idx + 1'b1;
                if (idx == LAST_IDX) result_reg <= {slice_cout, work_nxt};
            end
        end
    end

endmodule

// File: tb/tb_module_rca_seq_ctrl.sv
// Directed self-checking bench for module_rca_seq_ctrl with WIDTH=8, NWORDS=4.
module tb_module_rca_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int NWORDS = 4;
    localparam int TOTAL  = WIDTH * NWORDS;

    logic             clk_pi = 1'b0;
    logic             rst_n_pi = 1'b0;
    logic             valid_pi = 1'b0;
    logic             ready_po;
    logic             op_pi = 1'b0;
    logic [TOTAL-1:0] a_pi = '0;
    logic [TOTAL-1:0] b_pi = '0;
    logic             busy_po;
    logic             done_po;
    logic [TOTAL:0]   result_po;

    int errors = 0;
    int checks = 0;

    module_rca_seq_ctrl #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk_pi    (clk_pi),
        .rst_n_pi  (rst_n_pi),
        .valid_pi  (valid_pi),
        .ready_po  (ready_po),
        .op_pi     (op_pi),
        .a_pi      (a_pi),
        .b_pi      (b_pi),
        .busy_po   (busy_po),
        .done_po   (done_po),
        .result_po (result_po)
    );

    always #5 clk_pi = ~clk_pi;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one request from an idle, posedge+1 point and watches it to completion.
    task automatic run_op(input logic op, input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                          output logic [TOTAL:0] res, output int lat, output int busy_n,
                          output int done_n, output bit held, output bit timeout);
        logic [TOTAL:0] prev;
        prev    = result_po;
        res     = '0;
        lat     = -1;
        busy_n  = 0;
        done_n  = 0;
        held    = 1'b1;
        timeout = 1'b1;
        valid_pi = 1'b1;
        op_pi    = op;
        a_pi     = a;
        b_pi     = b;
        @(posedge clk_pi); #1;
        valid_pi = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy_po) busy_n++;
            if (done_po) begin
                done_n++;
                if (lat < 0) begin
                    lat = c;
                    res = result_po;
                end
            end else if (lat < 0 && result_po !== prev) begin
                held = 1'b0;
            end
            if (!busy_po) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk_pi); #1;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (busy_po !== 1'b0 || done_po !== 1'b0 || result_po !== '0) begin
            errors++;
            $display("FAIL reset_in: busy=%b done=%b result=%h expected 0 0 0", busy_po, done_po, result_po);
        end
        #9 rst_n_pi = 1'b1;
        @(posedge clk_pi); #1;
        checks++;
        if (ready_po !== 1'b1 || busy_po !== 1'b0 || done_po !== 1'b0 || result_po !== '0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b busy=%b done=%b result=%h expected 1 0 0 0",
                     ready_po, busy_po, done_po, result_po);
        end
    endtask

    task automatic test_add_ripple();
        logic [TOTAL:0] res;
        int lat, busy_n, done_n;
        bit held, timeout;
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, res, lat, busy_n, done_n, held, timeout);
        checks++;
        if (timeout || lat !== 4) begin
            errors++;
            $display("FAIL add_ripple_latency: got %0d (timeout=%0b) expected 4", lat, timeout);
        end
        checks++;
        if (res !== 33'h1_0000_0000) begin
            errors++;
            $display("FAIL add_ripple_result: got %h expected 100000000", res);
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL add_ripple_done_pulse: got %0d cycles expected 1", done_n);
        end
    endtask

    task automatic test_add_plain();
        logic [TOTAL:0] res;
        int lat, busy_n, done_n;
        bit held, timeout;
        run_op(1'b0, 32'h1234_5678, 32'h1111_1111, res, lat, busy_n, done_n, held, timeout);
        checks++;
        if (res !== 33'h0_2345_6789) begin
            errors++;
            $display("FAIL add_plain_result: got %h expected 023456789", res);
        end
        checks++;
        if (timeout || busy_n !== 5) begin
            errors++;
            $display("FAIL add_plain_busy: got %0d cycles (timeout=%0b) expected 5", busy_n, timeout);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL add_plain_hold: result changed before done, got %b expected 1", held);
        end
        checks++;
        if (ready_po !== 1'b1) begin
            errors++;
            $display("FAIL add_plain_ready_after: got %b expected 1", ready_po);
        end
    endtask

    task automatic test_sub();
        logic [TOTAL:0] res;
        int lat, busy_n, done_n;
        bit held, timeout;
        run_op(1'b1, 32'h0000_0005, 32'h0000_0003, res, lat, busy_n, done_n, held, timeout);
        checks++;
        if (timeout || lat !== 4 || res !== 33'h1_0000_0002) begin
            errors++;
            $display("FAIL sub_no_borrow: got %h lat %0d expected 100000002 lat 4", res, lat);
        end
        run_op(1'b1, 32'h0000_0003, 32'h0000_0005, res, lat, busy_n, done_n, held, timeout);
        checks++;
        if (timeout || lat !== 4 || res !== 33'h0_FFFF_FFFE) begin
            errors++;
            $display("FAIL sub_borrow: got %h lat %0d expected 0fffffffe lat 4", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [TOTAL-1:0] ta [3] = '{32'h0000_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [TOTAL-1:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        logic             top[3] = '{1'b0, 1'b1, 1'b0};
        logic [TOTAL:0]   tex[3] = '{33'h0_0001_0000, 33'h1_7FFF_FFFF, 33'h1_FFFF_FFFE};
        logic [TOTAL:0]   expq[$];
        logic [TOTAL:0]   exp_v;
        int sent = 0;
        int got = 0;
        int last_done = -1;
        valid_pi = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (done_po) begin
                got++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done: got result %h expected no done", result_po);
                end else begin
                    exp_v = expq.pop_front();
                    if (result_po !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_result%0d: got %h expected %h", got, result_po, exp_v);
                    end
                end
                if (last_done >= 0) begin
                    checks++;
                    if (c - last_done != NWORDS + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles expected %0d", c - last_done, NWORDS + 2);
                    end
                end
                last_done = c;
            end
            if (ready_po && sent < 3) begin
                op_pi = top[sent];
                a_pi  = ta[sent];
                b_pi  = tb[sent];
                expq.push_back(tex[sent]);
                sent++;
            end else if (!ready_po) begin
                // Operands that would corrupt a result if taken while busy.
                op_pi = c[0];
                a_pi  = 32'hDEAD_BEEF ^ 32'(c);
                b_pi  = 32'h0102_0304 + 32'(c);
            end
            if (got == 3) break;
            @(posedge clk_pi); #1;
        end
        valid_pi = 1'b0;
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones expected 3", got);
        end
        @(posedge clk_pi); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [TOTAL:0] res;
        int lat, busy_n, done_n, stray;
        bit held, timeout;
        valid_pi = 1'b1;
        op_pi    = 1'b0;
        a_pi     = 32'h0F0F_0F0F;
        b_pi     = 32'h0101_0101;
        @(posedge clk_pi); #1;
        valid_pi = 1'b0;
        @(posedge clk_pi); #1;
        @(posedge clk_pi); #1;
        rst_n_pi = 1'b0;
        #1;
        checks++;
        if (ready_po !== 1'b1 || busy_po !== 1'b0 || done_po !== 1'b0 || result_po !== '0) begin
            errors++;
            $display("FAIL midrun_reset: ready=%b busy=%b done=%b result=%h expected 1 0 0 0",
                     ready_po, busy_po, done_po, result_po);
        end
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_pi); #1;
            if (done_po) stray++;
        end
        rst_n_pi = 1'b1;
        @(posedge clk_pi); #1;
        if (done_po) stray++;
        checks++;
        if (stray !== 0 || ready_po !== 1'b1) begin
            errors++;
            $display("FAIL midrun_no_done: got %0d dones ready=%b expected 0 dones ready=1", stray, ready_po);
        end
        run_op(1'b0, 32'h0000_0001, 32'h0000_0001, res, lat, busy_n, done_n, held, timeout);
        checks++;
        if (timeout || lat !== 4 || res !== 33'h0_0000_0002) begin
            errors++;
            $display("FAIL post_reset_add: got %h lat %0d expected 000000002 lat 4", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_ripple();
        test_add_plain();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
